// File: rtl/enc_pkg.sv
// Shared types and address map for the encoder-block poll controller.
// The channel-search helpers keep the FSM free of inline loops.
package enc_pkg;

   typedef enum logic [2:0] {
      IDLE, SNAP, SCAN, RD_LO, RD_HI, CAP, PUSH, HOST
   } poll_state_t;

   localparam int          NUM_CH        = 8;
   localparam logic [15:0] ENC_POS_BASE  = 16'h0040;
   localparam logic [15:0] ENC_CH_STRIDE = 16'h0008;
   localparam logic [15:0] ENC_HI_OFS    = 16'h0002;

   // Lowest enabled channel at or above 'from'; NUM_CH when none remains.
   function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [3:0] from);
      next_ch = 4'(NUM_CH);
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= from)) next_ch = 4'(i);
      end
   endfunction

   function automatic logic no_ch_above(input logic [7:0] mask, input logic [3:0] cur);
      no_ch_above = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i] && (4'(i) > cur)) no_ch_above = 1'b0;
      end
   endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running poll period counter; emits a one-cycle tick every 'period' clocks
// while enabled, and sits at zero otherwise.
module poll_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                sclr,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                run;

   // The >= compare lets a shrinking period fire at once instead of wrapping.
   always_comb begin
      run  = enable && (period != '0);
      tick = run && (cnt_q >= (period - PERIOD_W'(1)));
      if (!run || tick) cnt_d = '0;
      else              cnt_d = cnt_q + PERIOD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (sclr) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/enc_poll_ctrl.sv
// Encoder-block bus master: snapshots all channels, reads the enabled positions
// and streams them out; host reads are slotted in between channel reads.
module enc_poll_ctrl
   import enc_pkg::*;
#(
   parameter logic [15:0] BAR       = 16'h0000,
   parameter logic [15:0] IDLE_ADDR = 16'hFFFF,
   parameter int          PERIOD_W  = 24
) (
   input  logic                clk,
   input  logic                sclr,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [7:0]          ch_mask,
   input  logic                sw_trig,
   output logic [15:0]         enc_rdaddr,
   input  logic [15:0]         enc_rddata,
   output logic                enc_snap,
   input  logic                host_rdreq,
   input  logic [15:0]         host_rdaddr,
   output logic                host_rdack,
   output logic [15:0]         host_rddata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_data,
   output logic [2:0]          out_ch,
   output logic                out_last,
   output logic                busy,
   output logic                overrun
);

   poll_state_t state_q, state_d, ret_q, ret_d;
   logic        host_ph_q, host_ph_d;
   logic [3:0]  ch_q, ch_d;
   logic [7:0]  mask_l_q, mask_l_d;
   logic [15:0] lo_q, lo_d, hi_q, hi_d;
   logic [15:0] host_rddata_q, host_rddata_d;
   logic        overrun_q, overrun_d;
   logic        tick, start, last;
   logic [3:0]  nxt_ch;
   logic [15:0] ch_addr;

   poll_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk    (clk),
      .sclr   (sclr),
      .enable (enable),
      .period (period),
      .tick   (tick)
   );

   assign start   = tick | sw_trig;
   assign nxt_ch  = next_ch(mask_l_q, ch_q);
   assign last    = no_ch_above(mask_l_q, ch_q);
   assign ch_addr = BAR + ENC_POS_BASE + (16'(ch_q) * ENC_CH_STRIDE);

   // NOTE: registers take only non-blocking updates; everything combinational is
   // computed in always_comb so no block both reads and writes the same flop.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q       <= IDLE;
         ret_q         <= IDLE;
         host_ph_q     <= 1'b0;
         ch_q          <= '0;
         mask_l_q      <= '0;
         lo_q          <= '0;
         hi_q          <= '0;
         host_rddata_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         host_ph_q     <= host_ph_d;
         ch_q          <= ch_d;
         mask_l_q      <= mask_l_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
         host_rddata_q <= host_rddata_d;
         overrun_q     <= overrun_d;
      end
   end

   // NOTE: every signal gets its hold value first, so no path leaves one unassigned.
   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      host_ph_d     = host_ph_q;
      ch_d          = ch_q;
      mask_l_d      = mask_l_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      host_rddata_d = host_rddata_q;
      overrun_d     = overrun_q | (start && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (host_rdreq) begin
               state_d   = HOST;
               ret_d     = IDLE;
               host_ph_d = 1'b0;
            end else if (start && (ch_mask != '0)) begin
               state_d = SNAP;
            end
         end
         SNAP: begin
            mask_l_d = ch_mask;
            ch_d     = '0;
            state_d  = SCAN;
         end
         SCAN: begin
            if (host_rdreq) begin
               state_d   = HOST;
               ret_d     = SCAN;
               host_ph_d = 1'b0;
            end else if (nxt_ch[3]) begin
               state_d = IDLE;
            end else begin
               ch_d    = nxt_ch;
               state_d = RD_LO;
            end
         end
         RD_LO: state_d = RD_HI;
         RD_HI: begin
            lo_d    = enc_rddata;
            state_d = CAP;
         end
         CAP: begin
            hi_d    = enc_rddata;
            state_d = PUSH;
         end
         PUSH: begin
            if (out_ready) begin
               if (last) begin
                  state_d = IDLE;
               end else begin
                  ch_d    = ch_q + 4'd1;
                  state_d = SCAN;
               end
            end
         end
         HOST: begin
            if (!host_ph_q) begin
               host_ph_d = 1'b1;
            end else begin
               host_ph_d     = 1'b0;
               host_rddata_d = enc_rddata;
               state_d       = ret_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Returned host data passes straight through in the ack cycle, then holds.
   always_comb begin
      enc_rdaddr  = IDLE_ADDR;
      enc_snap    = 1'b0;
      host_rdack  = 1'b0;
      host_rddata = host_rddata_q;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      case (state_q)
         SNAP:  enc_snap = 1'b1;
         RD_LO: enc_rdaddr = ch_addr;
         RD_HI: enc_rdaddr = ch_addr + ENC_HI_OFS;
         PUSH: begin
            out_valid = 1'b1;
            out_last  = last;
         end
         HOST: begin
            if (!host_ph_q) begin
               enc_rdaddr = host_rdaddr;
            end else begin
               host_rdack  = 1'b1;
               host_rddata = enc_rddata;
            end
         end
         default: ;
      endcase
   end

   assign out_data = {hi_q, lo_q};
   assign out_ch   = ch_q[2:0];
   assign busy     = (state_q != IDLE) && (state_q != HOST);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_enc_poll_ctrl.sv
// Directed bench for enc_poll_ctrl with a small registered encoder-block read model.
module tb_enc_poll_ctrl;

   typedef struct packed {
      logic        last;
      logic [2:0]  ch;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        sclr, enable, sw_trig, host_rdreq, out_ready;
   logic [23:0] period;
   logic [7:0]  ch_mask;
   logic [15:0] enc_rdaddr, enc_rddata, host_rdaddr, host_rddata;
   logic        enc_snap, host_rdack, out_valid, out_last, busy, overrun;
   logic [31:0] out_data;
   logic [2:0]  out_ch;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdack_n = 0;
   int snap_cyc[$];
   int acc_cyc[$];
   word_t words[$];
   logic [31:0] pos [8];

   always #5 clk = ~clk;

   enc_poll_ctrl #(.BAR(16'h0000), .IDLE_ADDR(16'hFFFF), .PERIOD_W(24)) dut (
      .clk         (clk),
      .sclr        (sclr),
      .enable      (enable),
      .period      (period),
      .ch_mask     (ch_mask),
      .sw_trig     (sw_trig),
      .enc_rdaddr  (enc_rdaddr),
      .enc_rddata  (enc_rddata),
      .enc_snap    (enc_snap),
      .host_rdreq  (host_rdreq),
      .host_rdaddr (host_rdaddr),
      .host_rdack  (host_rdack),
      .host_rddata (host_rddata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .out_last    (out_last),
      .busy        (busy),
      .overrun     (overrun)
   );

   // Encoder block: enable register at 'h04, positions lo/hi at 'h40+8*i / 'h42+8*i.
   function automatic logic [15:0] enc_read(input logic [15:0] a);
      enc_read = 16'hDEAD;
      if (a == 16'h0004) enc_read = 16'h00A5;
      for (int i = 0; i < 8; i++) begin
         if (a == 16'(16'h40 + 8 * i)) enc_read = pos[i][15:0];
         if (a == 16'(16'h42 + 8 * i)) enc_read = pos[i][31:16];
      end
   endfunction

   always @(posedge clk) enc_rddata <= enc_read(enc_rdaddr);
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (enc_snap) snap_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
         words.push_back({out_last, out_ch, out_data});
         acc_cyc.push_back(cyc);
      end
      if (host_rdack) rdack_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k = 0;
      while (busy && k < max) begin step(1); k++; end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_addr(input string tag, input logic [15:0] a, input int max);
      int k = 0;
      while (enc_rdaddr !== a && k < max) begin step(1); k++; end
      chk(tag, 32'(enc_rdaddr), 32'(a));
   endtask

   task automatic pulse_trig();
      sw_trig = 1'b1;
      step(1);
      sw_trig = 1'b0;
   endtask

   initial begin
      int n_s, n_w, k, r0, unstable, early;
      logic [31:0] d0;
      logic [2:0]  c0;
      pos[0] = 32'h0001_FFFE;
      pos[1] = 32'h1234_5678;
      pos[2] = 32'hFFFF_FFFB;
      for (int i = 3; i < 8; i++) pos[i] = 32'hA000_0000 + 32'(i);
      sclr = 1'b1; enable = 1'b0; period = '0; ch_mask = '0; sw_trig = 1'b0;
      host_rdreq = 1'b0; host_rdaddr = '0; out_ready = 1'b1;
      step(3);

      // Reset state
      chk("rst_rdaddr", 32'(enc_rdaddr), 32'h0000_FFFF);
      chk("rst_snap",   32'(enc_snap),   32'd0);
      chk("rst_valid",  32'(out_valid),  32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_ovr",    32'(overrun),    32'd0);
      chk("rst_rdack",  32'(host_rdack), 32'd0);
      chk("rst_data",   out_data,        32'd0);
      sclr = 1'b0;

      // 1: periodic polling, mask 05, period 100
      ch_mask = 8'h05; period = 24'd100; enable = 1'b1;
      n_s = snap_cyc.size(); n_w = words.size(); k = 0;
      while (snap_cyc.size() < n_s + 3 && k < 400) begin step(1); k++; end
      chk("t1_three_snaps", 32'(snap_cyc.size() >= n_s + 3), 32'd1);
      step(20);
      chk("t1_period_a", 32'(snap_cyc[n_s+1] - snap_cyc[n_s]),   32'd100);
      chk("t1_period_b", 32'(snap_cyc[n_s+2] - snap_cyc[n_s+1]), 32'd100);
      chk("t1_nwords",   32'(words.size() - n_w), 32'd6);
      chk("t1_latency",  32'(acc_cyc[n_w] - snap_cyc[n_s]), 32'd5);
      chk("t1_w0_data",  words[n_w].data,   32'h0001_FFFE);
      chk("t1_w0_ch",    32'(words[n_w].ch),   32'd0);
      chk("t1_w0_last",  32'(words[n_w].last), 32'd0);
      chk("t1_w1_data",  words[n_w+1].data, 32'hFFFF_FFFB);
      chk("t1_w1_ch",    32'(words[n_w+1].ch),   32'd2);
      chk("t1_w1_last",  32'(words[n_w+1].last), 32'd1);
      chk("t1_w5_data",  words[n_w+5].data, 32'hFFFF_FFFB);
      chk("t1_ovr",      32'(overrun), 32'd0);
      enable = 1'b0;
      wait_idle("t1_idle", 50);

      // 2: consumer stall with a tick arriving mid-frame
      out_ready = 1'b0; period = 24'd20; enable = 1'b1;
      n_w = words.size(); k = 0;
      while (!out_valid && k < 100) begin step(1); k++; end
      chk("t2_valid", 32'(out_valid), 32'd1);
      d0 = out_data; c0 = out_ch; n_s = snap_cyc.size(); unstable = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (out_data !== d0 || out_ch !== c0 || out_valid !== 1'b1) unstable++;
      end
      chk("t2_stable",   32'(unstable), 32'd0);
      chk("t2_data",     d0, 32'h0001_FFFE);
      chk("t2_ch",       32'(c0), 32'd0);
      chk("t2_overrun",  32'(overrun), 32'd1);
      chk("t2_no_snap",  32'(snap_cyc.size()), 32'(n_s));
      enable = 1'b0; out_ready = 1'b1;
      wait_idle("t2_idle", 50);
      chk("t2_nwords",   32'(words.size() - n_w), 32'd2);
      chk("t2_w0_data",  words[n_w].data, 32'h0001_FFFE);

      // 4: software trigger with polling off, then with an empty mask
      n_s = snap_cyc.size(); n_w = words.size();
      pulse_trig();
      step(20);
      chk("t4_one_snap", 32'(snap_cyc.size() - n_s), 32'd1);
      chk("t4_nwords",   32'(words.size() - n_w), 32'd2);
      chk("t4_w1_last",  32'(words[n_w+1].last), 32'd1);
      ch_mask = 8'h00; n_s = snap_cyc.size();
      pulse_trig();
      chk("t4_m0_busy",  32'(busy), 32'd0);
      step(5);
      chk("t4_m0_busy2", 32'(busy), 32'd0);
      chk("t4_m0_snap",  32'(snap_cyc.size()), 32'(n_s));

      // 3: host read of 'h04 slotted between channels of a 3-channel frame
      ch_mask = 8'h07; n_w = words.size(); r0 = rdack_n;
      pulse_trig();
      wait_addr("t3_rd_ch0", 16'h0040, 20);
      host_rdaddr = 16'h0004; host_rdreq = 1'b1; k = 0;
      while (!host_rdack && k < 30) begin step(1); k++; end
      chk("t3_rdack",    32'(host_rdack), 32'd1);
      chk("t3_rddata",   32'(host_rddata), 32'h0000_00A5);
      chk("t3_between",  32'(words.size() - n_w), 32'd1);
      host_rdreq = 1'b0;
      step(1);
      chk("t3_ack_pulse", 32'(host_rdack), 32'd0);
      step(20);
      chk("t3_ack_once", 32'(rdack_n - r0), 32'd1);
      chk("t3_hold",     32'(host_rddata), 32'h0000_00A5);
      chk("t3_nwords",   32'(words.size() - n_w), 32'd3);
      chk("t3_w0",       words[n_w].data,   32'h0001_FFFE);
      chk("t3_w1",       words[n_w+1].data, 32'h1234_5678);
      chk("t3_w1_ch",    32'(words[n_w+1].ch),   32'd1);
      chk("t3_w1_last",  32'(words[n_w+1].last), 32'd0);
      chk("t3_w2",       words[n_w+2].data, 32'hFFFF_FFFB);
      chk("t3_w2_last",  32'(words[n_w+2].last), 32'd1);

      // 5: sclr during RD_HI aborts the frame
      ch_mask = 8'h05;
      chk("t5_ovr_pre", 32'(overrun), 32'd1);
      pulse_trig();
      wait_addr("t5_rd_hi", 16'h0042, 20);
      sclr = 1'b1;
      step(1);
      chk("t5_valid",  32'(out_valid), 32'd0);
      chk("t5_rdaddr", 32'(enc_rdaddr), 32'h0000_FFFF);
      chk("t5_ovr",    32'(overrun), 32'd0);
      chk("t5_busy",   32'(busy), 32'd0);
      sclr = 1'b0; n_w = words.size();
      step(10);
      chk("t5_no_word", 32'(words.size()), 32'(n_w));

      // 6: period shrinks 1000 -> 10 while the counter sits at 500
      ch_mask = 8'h01; period = 24'd1000; enable = 1'b1; n_s = snap_cyc.size();
      step(500);
      chk("t6_no_tick", 32'(snap_cyc.size()), 32'(n_s));
      period = 24'd10;
      step(1);
      chk("t6_snap_now", 32'(enc_snap), 32'd1);
      for (int p = 0; p < 2; p++) begin
         early = 0;
         for (int i = 1; i < 10; i++) begin
            step(1);
            early += 32'(enc_snap);
         end
         step(1);
         chk("t6_quiet",  32'(early), 32'd0);
         chk("t6_snap10", 32'(enc_snap), 32'd1);
      end
      chk("t6_ovr", 32'(overrun), 32'd0);
      enable = 1'b0;
      wait_idle("t6_idle", 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
